// File: rtl/lfsr_checker_if.sv
// Sample/result bundle between an LFSR source (master) and the lfsr_checker (slave).
// The source drives the received word, taps and qualifiers; the checker drives lock and error status.
interface lfsr_checker_if #(
   parameter int WIDTH = 3,
   parameter int ERR_W = 16
);
   logic             enable;
   logic             restart;
   logic [WIDTH-1:0] config_taps;
   logic [WIDTH-1:0] data_in;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;

   modport master (
      output enable, restart, config_taps, data_in,
      input  locked, err_pulse, err_count
   );

   modport slave (
      input  enable, restart, config_taps, data_in,
      output locked, err_pulse, err_count
   );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: seeds from the received word, hunts for
// LOCK_COUNT consecutive predictions, then flywheels and counts mismatches until sync is lost.
module lfsr_checker #(
   parameter int WIDTH        = 3,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int ERR_W        = 16
) (
   input  logic         clk,
   input  logic         reset,
   lfsr_checker_if.slave bus
);
   typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);
   localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(LOCK_COUNT);
   localparam logic [MISS_W-1:0]  MISS_TARGET  = MISS_W'(UNLOCK_COUNT);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   expected_reg, expected_next;
   logic [MATCH_W-1:0] match_cnt_reg, match_cnt_next;
   logic [MISS_W-1:0]  miss_cnt_reg, miss_cnt_next;
   logic               locked_reg, locked_next;
   logic               err_pulse_reg, err_pulse_next;
   logic [ERR_W-1:0]   err_count_reg, err_count_next;

   logic [WIDTH-1:0]   data_nxt;
   logic [WIDTH-1:0]   exp_nxt;
   logic [MATCH_W-1:0] match_inc;
   logic [MISS_W-1:0]  miss_inc;
   logic               hit;
   logic               data_zero;

   // Successor words: shift left, feedback parity of the tapped bits into bit 0.
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_shift
         assign data_nxt[gi] = bus.data_in[gi-1];
         assign exp_nxt[gi]  = expected_reg[gi-1];
      end
   endgenerate
   assign data_nxt[0] = ^(bus.data_in & bus.config_taps);
   assign exp_nxt[0]  = ^(expected_reg & bus.config_taps);

   assign hit       = (bus.data_in == expected_reg);
   assign data_zero = (bus.data_in == '0);
   assign match_inc = match_cnt_reg + MATCH_W'(1);
   assign miss_inc  = miss_cnt_reg + MISS_W'(1);

   always_comb begin
      state_next     = state_reg;
      expected_next  = expected_reg;
      match_cnt_next = match_cnt_reg;
      miss_cnt_next  = miss_cnt_reg;
      locked_next    = locked_reg;
      err_pulse_next = 1'b0;
      err_count_next = err_count_reg;

      if (bus.restart) begin
         state_next     = SEED;
         expected_next  = '0;
         match_cnt_next = '0;
         miss_cnt_next  = '0;
         locked_next    = 1'b0;
         err_count_next = '0;
      end else if (bus.enable) begin
         case (state_reg)
            SEED: begin
               if (!data_zero) begin
                  expected_next  = data_nxt;
                  match_cnt_next = '0;
                  state_next     = HUNT;
               end
            end
            HUNT: begin
               if (hit) begin
                  expected_next  = data_nxt;
                  match_cnt_next = match_inc;
                  if (match_inc == MATCH_TARGET) begin
                     state_next    = LOCKED;
                     locked_next   = 1'b1;
                     miss_cnt_next = '0;
                  end
               end else begin
                  match_cnt_next = '0;
                  if (data_zero) begin
                     state_next = SEED;
                  end else begin
                     expected_next = data_nxt;
                  end
               end
            end
            LOCKED: begin
               // Flywheel: prediction advances from itself, never from the received word.
               expected_next = exp_nxt;
               if (hit) begin
                  miss_cnt_next = '0;
               end else begin
                  err_pulse_next = 1'b1;
                  miss_cnt_next  = miss_inc;
                  if (err_count_reg != '1) begin
                     err_count_next = err_count_reg + ERR_W'(1);
                  end
                  if (miss_inc == MISS_TARGET) begin
                     locked_next    = 1'b0;
                     match_cnt_next = '0;
                     miss_cnt_next  = '0;
                     expected_next  = data_nxt;
                     state_next     = data_zero ? SEED : HUNT;
                  end
               end
            end
            default: begin
               state_next = SEED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= SEED;
         expected_reg  <= '0;
         match_cnt_reg <= '0;
         miss_cnt_reg  <= '0;
         locked_reg    <= 1'b0;
         err_pulse_reg <= 1'b0;
         err_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         expected_reg  <= expected_next;
         match_cnt_reg <= match_cnt_next;
         miss_cnt_reg  <= miss_cnt_next;
         locked_reg    <= locked_next;
         err_pulse_reg <= err_pulse_next;
         err_count_reg <= err_count_next;
      end
   end

   assign bus.locked    = locked_reg;
   assign bus.err_pulse = err_pulse_reg;
   assign bus.err_count = err_count_reg;
endmodule
